// File: rtl/modn_bcd_counter.sv
// Modulo-MOD two-digit BCD counter with an on-chip prescaler tick enable; runs on the single system clock.
// Optional parallel load of a BCD value is compiled in when MODN_LOAD_EN is defined.
module modn_bcd_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int MOD     = 60
) (
  input  logic       clki,
  input  logic       rs,
  input  logic       en,
  input  logic       up_dn,
  input  logic       clr,
`ifdef MODN_LOAD_EN
  input  logic       ld,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_units,
`endif
  output logic [3:0] led1,
  output logic [3:0] led2,
  output logic       tick_o,
  output logic       carry_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  // Terminal count held as BCD digits, so no binary-to-BCD conversion is needed.
  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_U = 4'((MOD - 1) % 10);

  logic [DW-1:0] div_q, div_d;
  logic [3:0]    units_q, units_d;
  logic [3:0]    tens_q, tens_d;
  logic          tick_q, tick_d;
  logic          carry_q, carry_d;
  logic          step;

  assign step = en && (div_q == DIV_LAST);

`ifdef MODN_LOAD_EN
  logic [7:0] ld_val;
  logic       ld_ok;

  assign ld_val = ({4'd0, ld_tens} * 8'd10) + {4'd0, ld_units};
  assign ld_ok  = ld && (ld_tens <= 4'd9) && (ld_units <= 4'd9) && (ld_val < 8'(MOD));
`endif

  always_comb begin
    div_d   = div_q;
    units_d = units_q;
    tens_d  = tens_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (clr) begin
      div_d   = '0;
      units_d = 4'd0;
      tens_d  = 4'd0;
    end
`ifdef MODN_LOAD_EN
    else if (ld_ok) begin
      div_d   = '0;
      units_d = ld_units;
      tens_d  = ld_tens;
    end
`endif
    else if (en) begin
      div_d = step ? '0 : div_q + 1'b1;
      if (step) begin
        tick_d = 1'b1;
        if (up_dn) begin
          if (tens_q == MAX_T && units_q == MAX_U) begin
            units_d = 4'd0;
            tens_d  = 4'd0;
            carry_d = 1'b1;
          end else if (units_q == 4'd9) begin
            units_d = 4'd0;
            tens_d  = tens_q + 4'd1;
          end else begin
            units_d = units_q + 4'd1;
          end
        end else begin
          if (tens_q == 4'd0 && units_q == 4'd0) begin
            units_d = MAX_U;
            tens_d  = MAX_T;
            carry_d = 1'b1;
          end else if (units_q == 4'd0) begin
            units_d = 4'd9;
            tens_d  = tens_q - 4'd1;
          end else begin
            units_d = units_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      div_q   <= '0;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign led1    = units_q;
  assign led2    = tens_q;
  assign tick_o  = tick_q;
  assign carry_o = carry_q;

endmodule

// File: doc/modn_bcd_counter.md
Name: modn_bcd_counter

Overview:
Parametrised modulo-N two-digit BCD counter with an integrated prescaler. The prescaler produces a single-cycle tick enable, so the whole block runs on the one system clock and no divided clock is generated. The count can run up or down, can pause, and can be cleared synchronously. Outputs are two BCD digits that feed the TM1638 display path directly, plus a wrap pulse for cascading into the next stage, for example seconds into minutes.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz.
TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer ≥1.
MOD, 60, count modulus. Legal range 2..100; the count runs 0..MOD-1.

Ports:
clki  in  1  system clock, rising edge.
rs  in  1  reset, asynchronous, active-low.
en  in  1  run enable. When low, the prescaler and the count hold.
up_dn  in  1  direction: 1 = up, 0 = down.
clr  in  1  synchronous clear, highest synchronous priority.
led1  out  4  units BCD digit, 0..9.
led2  out  4  tens BCD digit, 0..9.
tick_o  out  1  one-cycle pulse on every count step.
carry_o  out  1  one-cycle pulse on wrap (up: MOD-1→0; down: 0→MOD-1).

Behaviour:
- Reset (rs=0), asynchronous: div_cnt=0, led1=0, led2=0, tick_o=0, carry_o=0. The block resumes on the first clki edge after rs rises.
- All outputs are registered. tick_o and carry_o default to 0 on every edge unless set as described below.
- Prescaler: div_cnt is $clog2(DIV) bits wide, minimum 1 bit.
  - On an edge with en=1: if div_cnt==DIV-1, div_cnt→0 and a step occurs; otherwise div_cnt+1.
  - DIV=1 gives a step on every enabled edge.
  - On an edge with en=0: div_cnt, led1 and led2 hold.
- Step, all on the same edge:
  - tick_o←1.
  - The digit update is visible together with tick_o.
  - up_dn is sampled on the step edge only.
- Up step:
  - If value==MOD-1: led2:led1→0:0 and carry_o←1.
  - Else if led1==9: led1→0, led2+1.
  - Else: led1+1.
- Down step:
  - If value==0: led2:led1→(MOD-1)/10 : (MOD-1)%10 and carry_o←1.
  - Else if led1==0: led1→9, led2-1.
  - Else: led1-1.
- Value = 10*led2 + led1. The comparison against MOD-1 uses BCD constants computed at elaboration; there is no binary-to-BCD converter.
- MOD=100: the wrap is 99→00, with led2 rolling through 9.
- clr=1 on an edge:
  - div_cnt, led1 and led2 →0; tick_o=0, carry_o=0.
  - Overrides a coincident step and ignores en.
- Priority: rs > clr > (load, if compiled) > step > hold.
- Out-of-range value: cannot occur without load. Load rejects such values (see below), so the invariant value<MOD always holds.
- Reset mid-count: immediate zero. No pulse is emitted on the release of rs.

Optional Feature:
Macro MODN_LOAD_EN.
- Defined: adds ports ld (in, 1), ld_tens (in, 4) and ld_units (in, 4).
- ld=1 and clr=0 on an edge:
  - If ld_tens≤9, ld_units≤9 and 10*ld_tens+ld_units<MOD: led2←ld_tens, led1←ld_units, div_cnt←0.
  - tick_o and carry_o are not asserted.
  - Load overrides a coincident step.
- ld=1 with an invalid value: the load is ignored entirely, and a coincident step proceeds normally.
- Undefined: the three ports do not exist and no load logic is synthesised.

Test Plan:
1. CLK_HZ=4, TICK_HZ=1, MOD=60, en=1, up_dn=1; assert rs=0 mid-count at value 37 → led2:led1=0:0 immediately, without waiting for a clock edge; first tick_o 4 cycles after rs release.
2. Same setup, count up from 0 → after 59 steps (236 cycles) led2=5, led1=9. Step 60 gives 0:0 with carry_o=1 for exactly one cycle. tick_o is high every 4th cycle, and carry_o is high in no other cycle.
3. up_dn=0 from 0:0 → first step gives 5:9 with carry_o=1; next step gives 5:8 with carry_o=0; from 1:0 the next step gives 0:9.
4. en=0 for 10 cycles when div_cnt=2 → led and div_cnt unchanged, no pulses. After en=1, tick_o follows 2 cycles later (DIV-1-2+1).
5. MOD=24, DIV=1, up: 2:3 → 0:0 with carry_o=1. MOD=100: 9:9 → 0:0 with carry_o=1. clr=1 coincident with the 2:3 step → 0:0 with tick_o=0 and carry_o=0.
6. MODN_LOAD_EN, MOD=60:
   - ld with 4,5 → 4:5 and div_cnt=0.
   - ld with 6,0 → ignored; the step proceeds.
   - ld with 1,10 → ignored.
   - clr and ld together → 0:0.
